multicycle_ctrl_fsm: RTL

- Main multicycle control sequencer for the processor control unit.
- Decodes the latched instruction fields op, funct and rd, and steps the datapath through fetch, decode, execute and writeback.
- Produces the unconditioned strobes pc_src, reg_write, mem_write, no_write and flag_write. The downstream condition-check logic gates these with the condition flags.
- Adds a memory ready handshake so that memory accesses can take more than one cycle.

---
 rtl/multicycle_ctrl_fsm.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control sequencer: fetch/decode/execute/writeback with a memory ready handshake.
// Optional CTRL_FSM_PERF_EN adds instr_count / stall_count performance counters.
module multicycle_ctrl_fsm #(
   parameter int STATE_W  = 4,
   parameter int DP_ALU_W = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [1:0]          op,
   input  logic [5:0]          funct,
   input  logic [3:0]          rd,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                adr_src,
   output logic                ir_write,
   output logic                pc_write,
   output logic                pc_src,
   output logic                reg_write,
   output logic                mem_write,
   output logic                no_write,
   output logic [1:0]          flag_write,
   output logic [1:0]          alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [1:0]          result_src,
   output logic [DP_ALU_W-1:0] alu_control,
   output logic                illegal,
   output logic [STATE_W-1:0]  dbg_state
`ifdef CTRL_FSM_PERF_EN
   ,
   output logic [31:0]         instr_count,
   output logic [31:0]         stall_count
`endif
);

   typedef enum logic [STATE_W-1:0] {
      FETCH  = STATE_W'(0),
      DECODE = STATE_W'(1),
      MEMADR = STATE_W'(2),
      MEMRD  = STATE_W'(3),
      MEMWB  = STATE_W'(4),
      MEMWR  = STATE_W'(5),
      EXECR  = STATE_W'(6),
      EXECI  = STATE_W'(7),
      ALUWB  = STATE_W'(8),
      BRANCH = STATE_W'(9)
   } state_t;

   localparam logic [DP_ALU_W-1:0] ALU_ADD = DP_ALU_W'(0);
   localparam logic [DP_ALU_W-1:0] ALU_SUB = DP_ALU_W'(1);
   localparam logic [DP_ALU_W-1:0] ALU_AND = DP_ALU_W'(2);
   localparam logic [DP_ALU_W-1:0] ALU_ORR = DP_ALU_W'(3);

   state_t                state;
   logic [3:0]            cmd;
   logic                  imm_bit;
   logic                  s_bit;
   logic                  dp_cmp;
   logic                  dp_nw;
   logic [DP_ALU_W-1:0]   dp_alu;
   logic [1:0]            dp_flags;

   assign cmd       = funct[4:1];
   assign imm_bit   = funct[5];
   assign s_bit     = funct[0];
   assign dbg_state = state;

   // Data-processing command decode; unknown commands execute as ADD without writeback.
   always_comb begin
      dp_cmp = 1'b0;
      dp_nw  = 1'b0;
      dp_alu = ALU_ADD;
      case (cmd)
         4'b0100: dp_alu = ALU_ADD;
         4'b0010: dp_alu = ALU_SUB;
         4'b0000: dp_alu = ALU_AND;
         4'b1100: dp_alu = ALU_ORR;
         4'b1010: begin
            dp_alu = ALU_SUB;
            dp_cmp = 1'b1;
            dp_nw  = 1'b1;
         end
         default: dp_nw = 1'b1;
      endcase
      if (dp_cmp)
         dp_flags = 2'b11;
      else
         dp_flags = {s_bit, s_bit & ((dp_alu == ALU_ADD) | (dp_alu == ALU_SUB))};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
`ifdef CTRL_FSM_PERF_EN
         instr_count <= '0;
         stall_count <= '0;
`endif
      end else begin
         case (state)
            FETCH:  if (mem_ready) state <= DECODE;
            DECODE: begin
               case (op)
                  2'b00:   state <= imm_bit ? EXECI : EXECR;
                  2'b01:   state <= MEMADR;
                  2'b10:   state <= BRANCH;
                  default: state <= FETCH;
               endcase
            end
            MEMADR: state <= s_bit ? MEMRD : MEMWR;
            MEMRD:  if (mem_ready) state <= MEMWB;
            MEMWB:  state <= FETCH;
            MEMWR:  if (mem_ready) state <= FETCH;
            EXECR:  state <= ALUWB;
            EXECI:  state <= ALUWB;
            ALUWB:  state <= FETCH;
            BRANCH: state <= FETCH;
            default: state <= FETCH;
         endcase
`ifdef CTRL_FSM_PERF_EN
         if ((state == MEMWB) || (state == ALUWB) || (state == BRANCH) ||
             ((state == MEMWR) && mem_ready) || ((state == DECODE) && (op == 2'b11)))
            instr_count <= instr_count + 32'd1;
         if (((state == FETCH) || (state == MEMRD) || (state == MEMWR)) && !mem_ready)
            stall_count <= stall_count + 32'd1;
`endif
      end
   end

   // Strobes are decoded from the current state and held at zero throughout reset.
   always_comb begin
      mem_req     = 1'b0;
      adr_src     = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 1'b0;
      reg_write   = 1'b0;
      mem_write   = 1'b0;
      no_write    = 1'b0;
      flag_write  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      result_src  = 2'b00;
      alu_control = ALU_ADD;
      illegal     = 1'b0;
      if (!reset) begin
         case (state)
            FETCH: begin
               mem_req    = 1'b1;
               alu_src_a  = 2'b01;
               alu_src_b  = 2'b10;
               result_src = 2'b10;
               ir_write   = mem_ready;
               pc_write   = mem_ready;
            end
            DECODE: begin
               alu_src_a  = 2'b01;
               alu_src_b  = 2'b10;
               result_src = 2'b10;
               illegal    = (op == 2'b11);
            end
            MEMADR: alu_src_b = 2'b01;
            MEMRD: begin
               mem_req = 1'b1;
               adr_src = 1'b1;
            end
            MEMWB: begin
               result_src = 2'b01;
               reg_write  = 1'b1;
               pc_src     = (rd == 4'd15);
            end
            MEMWR: begin
               mem_req   = 1'b1;
               adr_src   = 1'b1;
               mem_write = 1'b1;
            end
            EXECR, EXECI: begin
               alu_src_b   = (state == EXECI) ? 2'b01 : 2'b00;
               alu_control = dp_alu;
               flag_write  = dp_flags;
               no_write    = dp_nw;
            end
            ALUWB: begin
               reg_write = 1'b1;
               no_write  = dp_nw;
               pc_src    = (rd == 4'd15) & ~dp_nw;
            end
            BRANCH: begin
               alu_src_a  = 2'b10;
               alu_src_b  = 2'b01;
               result_src = 2'b10;
               pc_src     = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
